// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock divider bank.
package clkdiv_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ch_state_e;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;
endpackage

// File: rtl/clkdiv_if.sv
// Control and output bundle between a bank controller and the divider bank.
interface clkdiv_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH*DIV_W-1:0] div_value;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       active;

    modport master (
        output enable, mode, div_value,
        input  clk_out, tick, active
    );

    modport slave (
        input  enable, mode, div_value,
        output clk_out, tick, active
    );
endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: toggle (50% duty) or one-cycle pulse output, all outputs registered.
//   state | meaning
//   IDLE  | stopped, counter cleared, outputs low
//   RUN   | counting, output follows terminal events
//   DRAIN | toggle disabled while high: finish the high half-period, then stop
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic [DIV_W-1:0] div_value,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);
    ch_state_e        state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_sh, div_sh_nxt;
    logic             mode_q, mode_nxt;
    logic             clk_nxt;
    logic             term;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            div_sh  <= '0;
            mode_q  <= MODE_TOGGLE;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            active  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_sh  <= div_sh_nxt;
            mode_q  <= mode_nxt;
            clk_out <= clk_nxt;
            tick    <= clk_nxt & ~clk_out;
            active  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        div_sh_nxt = div_sh;
        mode_nxt   = mode_q;
        clk_nxt    = clk_out;
        term       = (cnt == div_sh);
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (enable) begin
                    state_nxt  = RUN;
                    div_sh_nxt = div_value;
                    mode_nxt   = mode;
                end
            end
            default: begin
                cnt_nxt = term ? '0 : cnt + DIV_W'(1);
                // divider updates only land on a terminal event, so no half-period is cut short
                if (term) div_sh_nxt = div_value;
                if (mode_q == MODE_PULSE) clk_nxt = term;
                else if (term)            clk_nxt = ~clk_out;
                if (enable) begin
                    state_nxt = RUN;
                end else if (mode_q == MODE_PULSE || !clk_out || term) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                end else begin
                    state_nxt = DRAIN;
                end
            end
        endcase
    end
endmodule

// File: rtl/clkdiv_bank.sv
// Bank of NUM_CH independent clock dividers sharing one system clock.
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
) (
    input  logic     clk,
    input  logic     reset,
    clkdiv_if.slave  bus
);
    logic [NUM_CH-1:0] clk_out_w;
    logic [NUM_CH-1:0] tick_w;
    logic [NUM_CH-1:0] active_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(.DIV_W(DIV_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (bus.enable[i]),
            .mode      (bus.mode[i]),
            .div_value (bus.div_value[i*DIV_W +: DIV_W]),
            .clk_out   (clk_out_w[i]),
            .tick      (tick_w[i]),
            .active    (active_w[i])
        );
    end

    assign bus.clk_out = clk_out_w;
    assign bus.tick    = tick_w;
    assign bus.active  = active_w;
endmodule

// File: tb/tb_clkdiv_bank.sv
// Bench for clkdiv_bank: event-time model checked every cycle plus directed period measurements.
module tb_clkdiv_bank;
    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    clkdiv_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus();

    clkdiv_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: each running channel knows the absolute edge index of its next output change.
    longint cyc = 0;
    bit     m_on   [NUM_CH];
    bit     m_mode [NUM_CH];
    bit     m_lvl  [NUM_CH];
    bit     m_tick [NUM_CH];
    longint m_tnext[NUM_CH];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_on[i] = 1'b0; m_mode[i] = 1'b0; m_lvl[i] = 1'b0;
                m_tick[i] = 1'b0; m_tnext[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < NUM_CH; i++) begin
                bit     prev;
                longint dv;
                prev = m_lvl[i];
                dv   = longint'(bus.div_value[i*DIV_W +: DIV_W]);
                if (!m_on[i]) begin
                    m_lvl[i] = 1'b0;
                    if (bus.enable[i]) begin
                        m_on[i]    = 1'b1;
                        m_mode[i]  = bus.mode[i];
                        m_tnext[i] = cyc + dv + 1;
                    end
                end else if (!bus.enable[i] && (m_mode[i] || !m_lvl[i] || cyc == m_tnext[i])) begin
                    m_on[i]  = 1'b0;
                    m_lvl[i] = 1'b0;
                end else if (cyc == m_tnext[i]) begin
                    m_tnext[i] = cyc + dv + 1;
                    m_lvl[i]   = m_mode[i] ? 1'b1 : ~m_lvl[i];
                end else if (m_mode[i]) begin
                    m_lvl[i] = 1'b0;
                end
                m_tick[i] = m_lvl[i] && !prev;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                logic [2:0] act, exp;
                act = {bus.clk_out[i], bus.tick[i], bus.active[i]};
                exp = {m_lvl[i], m_tick[i], m_on[i]};
                total++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL cycle%0d ch%0d clk_out/tick/active: got %b expected %b", cyc, i, act, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit cond_met(input int sel, input int ch);
        case (sel)
            0:       return bus.tick[ch] == 1'b1;
            1:       return bus.clk_out[ch] == 1'b0;
            default: return bus.active[ch] == 1'b0;
        endcase
    endfunction

    // sel: 0 = tick seen, 1 = clk_out low, 2 = active low; n = posedges counted
    task automatic wait_for(input int sel, input int ch, input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!cond_met(sel, ch) && n < budget);
        if (!cond_met(sel, ch)) begin
            total++;
            bad++;
            $display("FAIL timeout sel%0d ch%0d: got no event expected one within %0d cycles", sel, ch, budget);
        end
    endtask

    task automatic set_ch(input int ch, input bit en, input bit md, input int n);
        @(negedge clk);
        bus.enable[ch] = en;
        bus.mode[ch]   = md;
        bus.div_value[ch*DIV_W +: DIV_W] = DIV_W'(n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p, h;
        int exp_p[NUM_CH];
        exp_p = '{2, 4, 8, 16};
        reset = 1'b1;
        bus.enable = '0;
        bus.mode = '0;
        bus.div_value = '0;
        #22;
        check("reset clk_out", bus.clk_out, 0);
        check("reset tick", bus.tick, 0);
        check("reset active", bus.active, 0);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // ch0 toggle N=0 then N=3
        set_ch(0, 1'b1, 1'b0, 0);
        wait_for(0, 0, 10, n);   check("ch0 N0 first rise", n, 2);
        wait_for(0, 0, 10, p);   check("ch0 N0 period", p, 2);
        set_ch(0, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        set_ch(0, 1'b1, 1'b0, 3);
        wait_for(0, 0, 20, n);   check("ch0 N3 first rise", n, 5);
        wait_for(0, 0, 20, p);   check("ch0 N3 period", p, 8);
        wait_for(1, 0, 20, h);   check("ch0 N3 high", h, 4);
        wait_for(0, 0, 20, n);   check("ch0 N3 low", n, 4);
        set_ch(0, 1'b0, 1'b0, 3);
        wait_for(2, 0, 20, n);

        // ch1 toggle N=255, shrink to N=1 mid-high
        set_ch(1, 1'b1, 1'b0, 255);
        wait_for(0, 1, 600, n);  check("ch1 N255 first rise", n, 257);
        wait_for(0, 1, 600, p);  check("ch1 N255 period", p, 512);
        repeat (100) @(posedge clk);
        set_ch(1, 1'b1, 1'b0, 1);
        wait_for(1, 1, 600, h);  check("ch1 high across change", 100 + h, 256);
        wait_for(0, 1, 20, n);   check("ch1 low after change", n, 2);
        wait_for(0, 1, 20, p);   check("ch1 N1 period", p, 4);
        wait_for(1, 1, 20, h);   check("ch1 N1 high", h, 2);

        // ch2 pulse N=4 then N=0
        set_ch(2, 1'b1, 1'b1, 4);
        wait_for(0, 2, 20, n);   check("ch2 pulse first", n, 6);
        wait_for(0, 2, 20, p);   check("ch2 pulse period", p, 5);
        wait_for(1, 2, 20, h);   check("ch2 pulse width", h, 1);
        set_ch(2, 1'b1, 1'b1, 0);
        repeat (12) @(posedge clk);
        #1;
        check("ch2 N0 clk_out high", bus.clk_out[2], 1);
        check("ch2 N0 tick quiet", bus.tick[2], 0);

        // ch0 toggle N=7 drain, then re-enable during drain
        set_ch(0, 1'b1, 1'b0, 7);
        wait_for(0, 0, 20, n);   check("ch0 N7 first rise", n, 9);
        @(posedge clk);
        @(negedge clk);
        bus.enable[0] = 1'b0;
        wait_for(2, 0, 20, n);   check("ch0 drain length", n, 7);
        check("ch0 low after drain", bus.clk_out[0], 0);
        set_ch(0, 1'b1, 1'b0, 7);
        wait_for(0, 0, 20, n);
        @(posedge clk);
        @(negedge clk);
        bus.enable[0] = 1'b0;
        @(posedge clk); #1;
        check("ch0 draining active", bus.active[0], 1);
        @(negedge clk);
        bus.enable[0] = 1'b1;
        wait_for(0, 0, 30, n);   check("ch0 resume period", n + 2, 16);
        wait_for(0, 0, 30, p);   check("ch0 continued period", p, 16);

        // all channels toggle N=0,1,3,7, then flip mode while running
        @(negedge clk);
        bus.enable = '0;
        repeat (20) @(negedge clk);
        bus.mode = '0;
        bus.div_value = {8'd7, 8'd3, 8'd1, 8'd0};
        bus.enable = '1;
        for (int c = 0; c < NUM_CH; c++) begin
            wait_for(0, c, 40, n);
            wait_for(0, c, 40, p);
            check($sformatf("all ch%0d period", c), p, exp_p[c]);
        end
        @(negedge clk);
        bus.mode = '1;
        repeat (40) @(posedge clk);
        wait_for(0, 3, 40, n);
        wait_for(0, 3, 40, p);   check("ch3 period after mode flip", p, 16);
        wait_for(0, 0, 40, n);
        wait_for(0, 0, 40, p);   check("ch0 period after mode flip", p, 2);

        // asynchronous reset mid-operation, 20 ns
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.mode = '0;
        #1;
        check("async reset clk_out", bus.clk_out, 0);
        check("async reset tick", bus.tick, 0);
        check("async reset active", bus.active, 0);
        #19;
        reset = 1'b0;
        wait_for(0, 3, 20, n);   check("ch3 restart first rise", n, 9);

        repeat (10) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter DIV_W, default 8, width of each channel's divider value.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  NUM_CH  per-channel run request; bit i controls channel i.
REQ-006 mode  input  NUM_CH  per-channel mode: 0 = TOGGLE (50% duty), 1 = PULSE (one-cycle strobe).
REQ-007 div_value  input  NUM_CH*DIV_W  per-channel divider N; channel i uses bits [i*DIV_W +: DIV_W].
REQ-008 clk_out  output  NUM_CH  registered divided clock/strobe per channel.
REQ-009 tick  output  NUM_CH  one-cycle pulse per channel, coincident with each clk_out 0->1 transition.
REQ-010 active  output  NUM_CH  high while channel state is not IDLE.

Function
REQ-011 Each channel SHALL hold state IDLE/RUN/DRAIN, a DIV_W-bit counter cnt, a shadow divider div_sh and a latched mode bit.
REQ-012 IDLE: cnt=0, clk_out=0, tick=0; enable=1 sampled -> RUN next cycle, cnt<=0, div_sh<=div_value, mode latched.
REQ-013 RUN: cnt increments each cycle; at cnt==div_sh, cnt<=0 (terminal event) and div_sh<=div_value (current value).
REQ-014 TOGGLE: clk_out SHALL invert on each terminal event; period 2*(N+1) cycles, high and low each N+1 cycles.
REQ-015 TOGGLE: first clk_out rise SHALL occur N+1 cycles after the RUN-entry edge.
REQ-016 PULSE: clk_out SHALL be high for exactly the cycle after each terminal event; period N+1; N=0 gives clk_out constantly high.
REQ-017 tick SHALL be high for one cycle exactly when clk_out goes 0->1; in PULSE mode tick equals clk_out except that with N=0 tick pulses only on the first cycle.
REQ-018 div_value changes SHALL take effect only at the next terminal event; no clk_out half-period shorter than min(old,new)+1 cycles.
REQ-019 mode changes SHALL be ignored outside IDLE.
REQ-020 TOGGLE, enable=0 with clk_out=0 -> IDLE next cycle; with clk_out=1 -> DRAIN.
REQ-021 DRAIN: counting continues; at terminal event clk_out<=0 and state<=IDLE; enable=1 during DRAIN -> RUN with no counter disturbance.
REQ-022 PULSE, enable=0 -> IDLE next cycle, clk_out<=0.
REQ-023 Channels SHALL be fully independent; no cross-channel timing interaction.
REQ-024 Counter arithmetic SHALL be DIV_W wide; N=2^DIV_W-1 SHALL work without overflow.

Reset
REQ-025 reset=1 SHALL asynchronously force all channels to IDLE, cnt=0, div_sh=0, clk_out=0, tick=0, active=0.
REQ-026 Reset asserted mid-period SHALL truncate outputs immediately; after release a channel with enable=1 restarts per REQ-012 on the first clock edge.

Structure
REQ-027 Package clkdiv_pkg SHALL hold the channel state enum (IDLE, RUN, DRAIN) and mode constants MODE_TOGGLE=0, MODE_PULSE=1.
REQ-028 One sub-module clkdiv_channel (single channel, DIV_W parameter) SHALL be instantiated NUM_CH times by generate in clkdiv_bank.
REQ-029 All outputs SHALL be driven directly from flops; no combinational path from inputs to outputs.

Verification
REQ-030 ch0 TOGGLE N=0, enable=1 -> clk_out period 2 cycles, tick every 2 cycles; N=3 -> period 8, high 4, low 4.
REQ-031 ch1 TOGGLE N=255 -> period 512; change N to 1 mid-high-phase -> current half-period completes at 256 cycles, then period 4.
REQ-032 ch2 PULSE N=4 -> one-cycle clk_out every 5 cycles, tick==clk_out; N=0 -> clk_out stays high.
REQ-033 ch0 TOGGLE N=7, drop enable 2 cycles into high phase -> active stays 1 for 6 more cycles, clk_out high full 8 cycles then low, IDLE; re-raise enable during DRAIN -> continuous 16-cycle period.
REQ-034 Assert reset for 20 ns mid-operation on all channels -> all outputs 0 asynchronously; after release channels restart per REQ-015.
REQ-035 All 4 channels N=0,1,3,7 simultaneously -> periods 2,4,8,16 with independent phases; mode toggled while RUN -> no effect.
